// File: rtl/demux_route_pkg.sv
// demux_route_pkg
// Shared definitions for the nibble router: default data width and FIFO
// depth, the width of the optional accepted-transfer counters, and the
// destination select encodings used by the producer side.
package demux_route_pkg;

    // Default nibble width and per-output FIFO depth (power of 2, >= 2)
    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 2;

    // Width of the optional per-destination transfer counters
    localparam int COUNT_W = 8;

    // Destination select encodings on in_sel
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage : demux_route_pkg

// File: rtl/route_fifo.sv
// route_fifo
// Parameterized synchronous FIFO used once per router output. The head entry
// is presented directly from storage and forced to zero while empty, so a
// consumer never sees stale data. Push and pop are qualified internally
// against full/empty so the caller may pass raw handshake terms.
//
// Ports:
//   clk     in  1      rising-edge clock
//   rst     in  1      synchronous active-high reset (pointers, occupancy)
//   push_i  in  1      write data_i at this edge (ignored when full)
//   data_i  in  WIDTH  entry to write
//   pop_i   in  1      advance the read pointer (ignored when empty)
//   head_o  out WIDTH  oldest entry, 0 when empty
//   full_o  out 1      occupancy equals DEPTH
//   empty_o out 1      occupancy is zero
module route_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    logic doPush;
    logic doPop;

    assign full_o  = (occ_q == OCC_W'(DEPTH));
    assign empty_o = (occ_q == '0);

    // A push into a full FIFO is dropped even if a pop happens in the same
    // cycle: there is deliberately no pass-through path.
    assign doPush = push_i && !full_o;
    assign doPop  = pop_i && !empty_o;

    assign head_o = empty_o ? '0 : mem_q[rdPtr_q];

    // Next-state pointers and occupancy. Pointers wrap naturally because
    // DEPTH is a power of two and they are exactly log2(DEPTH) bits wide.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        occ_d   = occ_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        case ({doPush, doPop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Control state; reset discards everything by clearing occupancy, the
    // storage itself does not need clearing because the head is masked.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            occ_q   <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            occ_q   <= occ_d;
        end
    end

    // Storage write port, kept free of reset so it maps onto plain registers
    // or a small RAM.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

endmodule : route_fifo

// File: rtl/demux4bit_route.sv
// demux4bit_route
// Registered 1-to-2 nibble router. Each input nibble is steered by in_sel
// into one of two independent FIFOs (A or B), each drained by its own
// valid/ready consumer. in_ready reflects only the selected destination, so a
// stalled consumer never blocks traffic heading to the other one.
//
// Optional feature macro: DEMUX_ROUTE_COUNT_EN adds a_count/b_count, 8-bit
// wrapping counters of accepted transfers per destination.
//
// Ports:
//   clk      in  1      rising-edge clock
//   rst      in  1      synchronous active-high reset
//   in_data  in  WIDTH  nibble to route
//   in_sel   in  1      destination, 0 -> A, 1 -> B
//   in_valid in  1      producer offers in_data/in_sel
//   in_ready out 1      selected destination has space this cycle
//   a_data   out WIDTH  head of FIFO A, 0 when empty
//   a_valid  out 1      FIFO A non-empty
//   a_ready  in  1      consumer A takes the head
//   b_data   out WIDTH  head of FIFO B, 0 when empty
//   b_valid  out 1      FIFO B non-empty
//   b_ready  in  1      consumer B takes the head
//   a_count  out 8      accepted transfers to A (macro only)
//   b_count  out 8      accepted transfers to B (macro only)
module demux4bit_route
    import demux_route_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   a_data,
    output logic               a_valid,
    input  logic               a_ready,
    output logic [WIDTH-1:0]   b_data,
    output logic               b_valid,
    input  logic               b_ready
`ifdef DEMUX_ROUTE_COUNT_EN
    ,
    output logic [COUNT_W-1:0] a_count,
    output logic [COUNT_W-1:0] b_count
`endif
);

    logic aFull, aEmpty;
    logic bFull, bEmpty;
    logic selA, selB;
    logic pushA, pushB;

    // Select decode
    assign selA = (in_sel == SEL_A);
    assign selB = (in_sel == SEL_B);

    // Readiness depends only on the addressed FIFO and never on in_valid
    assign in_ready = selB ? !bFull : !aFull;

    // A transfer happens only on a full handshake, routed by the select
    assign pushA = in_valid && in_ready && selA;
    assign pushB = in_valid && in_ready && selB;

    assign a_valid = !aEmpty;
    assign b_valid = !bEmpty;

    route_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifoA (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pushA),
        .data_i  (in_data),
        .pop_i   (a_ready),
        .head_o  (a_data),
        .full_o  (aFull),
        .empty_o (aEmpty)
    );

    route_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifoB (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pushB),
        .data_i  (in_data),
        .pop_i   (b_ready),
        .head_o  (b_data),
        .full_o  (bFull),
        .empty_o (bEmpty)
    );

`ifdef DEMUX_ROUTE_COUNT_EN
    logic [COUNT_W-1:0] aCount_q;
    logic [COUNT_W-1:0] bCount_q;

    // Accepted-transfer counters; they wrap silently at 255 -> 0
    always_ff @(posedge clk) begin
        if (rst) begin
            aCount_q <= '0;
            bCount_q <= '0;
        end else begin
            if (pushA) begin
                aCount_q <= aCount_q + 1'b1;
            end
            if (pushB) begin
                bCount_q <= bCount_q + 1'b1;
            end
        end
    end

    assign a_count = aCount_q;
    assign b_count = bCount_q;
`endif

endmodule : demux4bit_route

// File: tb/tb_demux4bit_route.sv
// tb_demux4bit_route
// Directed bench for the nibble router (DEPTH=2). Inputs are driven on the
// falling edge and outputs sampled shortly after, well away from the rising
// edge where the DUT updates. Counter checks appear only when
// DEMUX_ROUTE_COUNT_EN is defined.
module tb_demux4bit_route;

    logic       clk;
    logic       rst;
    logic [3:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic [3:0] b_data;
    logic       b_valid;
    logic       b_ready;
`ifdef DEMUX_ROUTE_COUNT_EN
    logic [7:0] a_count;
    logic [7:0] b_count;
`endif

    int errors;
    int checks;

    demux4bit_route #(
        .WIDTH (4),
        .DEPTH (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready)
`ifdef DEMUX_ROUTE_COUNT_EN
        ,
        .a_count  (a_count),
        .b_count  (b_count)
`endif
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one full cycle, landing 1 ns after the falling edge
    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    // One push into a destination with its consumer stalled by the caller
    task automatic pushOne(input logic sel, input logic [3:0] data);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        nextCycle();
        in_valid = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b0; in_sel = 1'b0; in_data = 4'h0;
        a_ready = 1'b0; b_ready = 1'b0;
        doReset();
        checks++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid a_valid=%b b_valid=%b expected 0 0", a_valid, b_valid);
        end
        checks++;
        if (a_data !== 4'h0 || b_data !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_data a_data=%h b_data=%h expected 0 0", a_data, b_data);
        end
        in_sel = 1'b0; #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready_a in_ready=%b expected 1", in_ready);
        end
        in_sel = 1'b1; #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready_b in_ready=%b expected 1", in_ready);
        end
`ifdef DEMUX_ROUTE_COUNT_EN
        checks++;
        if (a_count !== 8'd0 || b_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_count a=%0d b=%0d expected 0 0", a_count, b_count);
        end
`endif
    endtask

    task automatic test_routing();
        a_ready = 1'b1; b_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h5;
        nextCycle();
        in_sel = 1'b1; in_data = 4'hA;
        checks++;
        if (a_valid !== 1'b1 || a_data !== 4'h5) begin
            errors++;
            $display("[TB] FAIL route_a got valid=%b data=%h expected 1 5", a_valid, a_data);
        end
        nextCycle();
        in_valid = 1'b0;
        checks++;
        if (b_valid !== 1'b1 || b_data !== 4'hA || a_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL route_b got b_valid=%b b_data=%h a_valid=%b expected 1 a 0",
                     b_valid, b_data, a_valid);
        end
        nextCycle();
        checks++;
        if (b_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL route_drain b_valid=%b expected 0", b_valid);
        end
`ifdef DEMUX_ROUTE_COUNT_EN
        checks++;
        if (a_count !== 8'd1 || b_count !== 8'd1) begin
            errors++;
            $display("[TB] FAIL route_count a=%0d b=%0d expected 1 1", a_count, b_count);
        end
`endif
    endtask

    task automatic test_full_isolation();
        a_ready = 1'b0; b_ready = 1'b0;
        pushOne(1'b0, 4'h1);
        pushOne(1'b0, 4'h2);
        in_sel = 1'b0; #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL iso_a_full in_ready=%b expected 0", in_ready);
        end
        in_sel = 1'b1; #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL iso_b_open in_ready=%b expected 1", in_ready);
        end
        pushOne(1'b1, 4'h3);
        checks++;
        if (b_valid !== 1'b1 || b_data !== 4'h3) begin
            errors++;
            $display("[TB] FAIL iso_b_push got valid=%b data=%h expected 1 3", b_valid, b_data);
        end
        a_ready = 1'b1; #1;
        checks++;
        if (a_valid !== 1'b1 || a_data !== 4'h1) begin
            errors++;
            $display("[TB] FAIL iso_drain1 got valid=%b data=%h expected 1 1", a_valid, a_data);
        end
        nextCycle();
        checks++;
        if (a_valid !== 1'b1 || a_data !== 4'h2) begin
            errors++;
            $display("[TB] FAIL iso_drain2 got valid=%b data=%h expected 1 2", a_valid, a_data);
        end
        b_ready = 1'b1;
        nextCycle();
        checks++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL iso_empty a_valid=%b b_valid=%b expected 0 0", a_valid, b_valid);
        end
    endtask

    task automatic test_full_pop();
        a_ready = 1'b0;
        pushOne(1'b0, 4'h4);
        pushOne(1'b0, 4'h5);
        a_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h6; #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fullpop_block in_ready=%b expected 0", in_ready);
        end
        nextCycle();
        checks++;
        if (in_ready !== 1'b1 || a_data !== 4'h5) begin
            errors++;
            $display("[TB] FAIL fullpop_next in_ready=%b a_data=%h expected 1 5", in_ready, a_data);
        end
        nextCycle();
        in_valid = 1'b0;
        checks++;
        if (a_valid !== 1'b1 || a_data !== 4'h6) begin
            errors++;
            $display("[TB] FAIL fullpop_order got valid=%b data=%h expected 1 6", a_valid, a_data);
        end
        nextCycle();
        checks++;
        if (a_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fullpop_empty a_valid=%b expected 0", a_valid);
        end
`ifdef DEMUX_ROUTE_COUNT_EN
        checks++;
        if (a_count !== 8'd6 || b_count !== 8'd2) begin
            errors++;
            $display("[TB] FAIL fullpop_count a=%0d b=%0d expected 6 2", a_count, b_count);
        end
`endif
    endtask

    task automatic test_wrap();
        int sent;
        int got;
        int cycles;
        sent = 0; got = 0; cycles = 0;
        in_sel = 1'b1;
        while (got < 16 && cycles < 400) begin
            b_ready  = 1'($urandom_range(0, 1));
            in_valid = (sent < 16);
            in_data  = 4'(sent);
            #1;
            if (b_valid && b_ready) begin
                checks++;
                if (b_data !== 4'(got)) begin
                    errors++;
                    $display("[TB] FAIL wrap_data got %h expected %h", b_data, 4'(got));
                end
                got++;
            end
            if (in_valid && in_ready) begin
                sent++;
            end
            nextCycle();
            cycles++;
        end
        in_valid = 1'b0; b_ready = 1'b1;
        checks++;
        if (got !== 16) begin
            errors++;
            $display("[TB] FAIL wrap_timeout received %0d expected 16", got);
        end
        nextCycle();
        checks++;
        if (b_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_empty b_valid=%b expected 0", b_valid);
        end
    endtask

    task automatic test_reset_mid();
        a_ready = 1'b0;
        pushOne(1'b0, 4'h8);
        pushOne(1'b0, 4'h9);
        doReset();
        checks++;
        if (a_valid !== 1'b0 || a_data !== 4'h0) begin
            errors++;
            $display("[TB] FAIL midrst_clear got valid=%b data=%h expected 0 0", a_valid, a_data);
        end
        pushOne(1'b0, 4'h7);
        checks++;
        if (a_valid !== 1'b1 || a_data !== 4'h7) begin
            errors++;
            $display("[TB] FAIL midrst_head got valid=%b data=%h expected 1 7", a_valid, a_data);
        end
        a_ready = 1'b1;
        nextCycle();
        checks++;
        if (a_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_alone a_valid=%b expected 0", a_valid);
        end
`ifdef DEMUX_ROUTE_COUNT_EN
        checks++;
        if (a_count !== 8'd1 || b_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL midrst_count a=%0d b=%0d expected 1 0", a_count, b_count);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int accepted;
        accepted = 0;
        doReset();
        a_ready = 1'b1; in_sel = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_data = 4'(i);
            #1;
            if (in_ready) begin
                accepted++;
            end
            nextCycle();
        end
        in_valid = 1'b0;
        checks++;
        if (accepted !== 300) begin
            errors++;
            $display("[TB] FAIL b2b_throughput accepted %0d expected 300", accepted);
        end
        checks++;
        if (a_valid !== 1'b1 || a_data !== 4'hB) begin
            errors++;
            $display("[TB] FAIL b2b_last got valid=%b data=%h expected 1 b", a_valid, a_data);
        end
`ifdef DEMUX_ROUTE_COUNT_EN
        checks++;
        if (a_count !== 8'd44) begin
            errors++;
            $display("[TB] FAIL b2b_count a_count=%0d expected 44", a_count);
        end
`endif
        nextCycle();
    endtask

    // Scenario sequence
    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        in_valid = 1'b0; in_sel = 1'b0; in_data = 4'h0;
        a_ready = 1'b0; b_ready = 1'b0;
        nextCycle();
        test_reset();
        test_routing();
        test_full_isolation();
        test_full_pop();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_demux4bit_route
